// File: rtl/arrow_lane_sequencer.sv
// Arrow track producer: scrolls two 26-slot tracks at a fixed step rate,
// loads slot 0 from the chart stream, judges presses and keeps scores.
module arrow_lane_sequencer #(
  parameter int unsigned STEP_CYCLES    = 1666667,
  parameter int unsigned INDICATOR_HOLD = 25000000,
  parameter logic [15:0] SCORE_MAX      = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        play_enable,
  input  logic        chart_valid,
  input  logic [2:0]  chart_code,
  output logic        chart_ready,
  input  logic        p1_press_valid,
  input  logic [2:0]  p1_press_code,
  input  logic        p2_press_valid,
  input  logic [2:0]  p2_press_code,
  output logic [77:0] p1_arrow_array,
  output logic [77:0] p2_arrow_array,
  output logic [1:0]  p1_indicator,
  output logic [1:0]  p2_indicator,
  output logic [15:0] p1_score,
  output logic [15:0] p2_score,
  output logic        step_pulse
);

  localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned HW = $clog2(INDICATOR_HOLD + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(INDICATOR_HOLD - 1);

  logic [CW-1:0] step_cnt;
  logic          step;

  logic [77:0] track_q [2];
  logic [77:0] track_d [2];
  logic [77:0] cleared [2];
  logic [1:0]  ind_q   [2];
  logic [HW-1:0] hold_q [2];
  logic [15:0] score_q [2];
  logic [15:0] score_d [2];
  logic [16:0] sum     [2];
  logic [1:0]  verdict [2];
  logic [1:0]  inc     [2];
  logic [1:0]  press_valid;
  logic [2:0]  press_code [2];
  logic [2:0]  ins;

  function automatic logic code_ok(input logic [2:0] c);
    return (c != 3'd0) && (c <= 3'd5);
  endfunction

  // Reset is gated in so a reset cycle never scrolls or consumes chart data.
  assign step        = play_enable && !reset && (step_cnt == STEP_LAST);
  assign step_pulse  = step;
  assign chart_ready = step;

  assign press_valid   = {p2_press_valid, p1_press_valid};
  assign press_code[0] = p1_press_code;
  assign press_code[1] = p2_press_code;

  assign p1_arrow_array = track_q[0];
  assign p2_arrow_array = track_q[1];
  assign p1_indicator   = ind_q[0];
  assign p2_indicator   = ind_q[1];
  assign p1_score       = score_q[0];
  assign p2_score       = score_q[1];

  // Judge on pre-step contents, then shift the (possibly cleared) track.
  always_comb begin
    ins = (chart_valid && code_ok(chart_code)) ? chart_code : 3'd0;
    for (int p = 0; p < 2; p++) begin
      cleared[p] = track_q[p];
      verdict[p] = 2'b00;
      inc[p]     = 2'd0;
      if (play_enable && press_valid[p] && code_ok(press_code[p])) begin
        verdict[p] = 2'b01;
        if (track_q[p][71:69] == press_code[p]) begin
          verdict[p] = 2'b11;
          inc[p]     = 2'd2;
          cleared[p][71:69] = 3'd0;
        end else if (track_q[p][68:66] == press_code[p]) begin
          verdict[p] = 2'b10;
          inc[p]     = 2'd1;
          cleared[p][68:66] = 3'd0;
        end else if (track_q[p][74:72] == press_code[p]) begin
          verdict[p] = 2'b10;
          inc[p]     = 2'd1;
          cleared[p][74:72] = 3'd0;
        end
      end
      if (step && (verdict[p] == 2'b00) && (track_q[p][77:75] != 3'd0)) begin
        verdict[p] = 2'b01;
      end
      track_d[p] = step ? {cleared[p][74:0], ins} : cleared[p];
      sum[p]     = {1'b0, score_q[p]} + 17'(inc[p]);
      score_d[p] = (sum[p] > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[p][15:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_cnt <= '0;
      for (int p = 0; p < 2; p++) begin
        track_q[p] <= '0;
        ind_q[p]   <= 2'b00;
        hold_q[p]  <= '0;
        score_q[p] <= '0;
      end
    end else begin
      if (play_enable) begin
        step_cnt <= step ? '0 : step_cnt + CW'(1);
      end
      for (int p = 0; p < 2; p++) begin
        track_q[p] <= track_d[p];
        score_q[p] <= score_d[p];
        // Hold timer runs regardless of play_enable.
        if (verdict[p] != 2'b00) begin
          ind_q[p]  <= verdict[p];
          hold_q[p] <= HOLD_LOAD;
        end else if (hold_q[p] != '0) begin
          hold_q[p] <= hold_q[p] - HW'(1);
        end else begin
          ind_q[p] <= 2'b00;
        end
      end
    end
  end

endmodule

// File: tb/tb_arrow_lane_sequencer.sv
// Scoreboard bench for arrow_lane_sequencer: a cycle model pushes expected
// outputs each cycle, which are popped and compared after the clock edge.
module tb_arrow_lane_sequencer;

  localparam int unsigned SC   = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned SMAX = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        play_enable = 1'b0;
  logic        chart_valid = 1'b0;
  logic [2:0]  chart_code = 3'd0;
  logic        chart_ready;
  logic        p1_press_valid = 1'b0;
  logic [2:0]  p1_press_code = 3'd0;
  logic        p2_press_valid = 1'b0;
  logic [2:0]  p2_press_code = 3'd0;
  logic [77:0] p1_arrow_array, p2_arrow_array;
  logic [1:0]  p1_indicator, p2_indicator;
  logic [15:0] p1_score, p2_score;
  logic        step_pulse;

  arrow_lane_sequencer #(
    .STEP_CYCLES(SC), .INDICATOR_HOLD(HOLD), .SCORE_MAX(16'(SMAX))
  ) dut (
    .clock(clock), .reset(reset), .play_enable(play_enable),
    .chart_valid(chart_valid), .chart_code(chart_code), .chart_ready(chart_ready),
    .p1_press_valid(p1_press_valid), .p1_press_code(p1_press_code),
    .p2_press_valid(p2_press_valid), .p2_press_code(p2_press_code),
    .p1_arrow_array(p1_arrow_array), .p2_arrow_array(p2_arrow_array),
    .p1_indicator(p1_indicator), .p2_indicator(p2_indicator),
    .p1_score(p1_score), .p2_score(p2_score), .step_pulse(step_pulse)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [77:0] a1, a2;
    logic [1:0]  i1, i2;
    logic [15:0] s1, s2;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nerr = 0;

  int m_trk [2][26];
  int m_score [2];
  int m_ind [2];
  int m_hold [2];
  int m_cnt;

  function automatic logic [77:0] pack_trk(input int p);
    logic [77:0] r;
    r = '0;
    for (int k = 0; k < 26; k++) r[3*k +: 3] = 3'(m_trk[p][k]);
    return r;
  endfunction

  function automatic bit valid_code(input int c);
    return (c >= 1) && (c <= 5);
  endfunction

  // One clock: check combinational strobes, advance model, compare after edge.
  task automatic tick();
    bit   st;
    int   pv [2];
    int   pc [2];
    int   v, inc;
    exp_t e, g;
    #1;
    st = (play_enable == 1'b1) && (reset == 1'b0) && (m_cnt == SC - 1);
    nvec++;
    if (step_pulse !== st || chart_ready !== st) begin
      $display("FAIL strobe t=%0t step_pulse=%b chart_ready=%b want %b", $time, step_pulse, chart_ready, st);
      nerr++;
    end
    pv[0] = p1_press_valid; pc[0] = p1_press_code;
    pv[1] = p2_press_valid; pc[1] = p2_press_code;
    if (reset) begin
      m_cnt = 0;
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < 26; k++) m_trk[p][k] = 0;
        m_score[p] = 0; m_ind[p] = 0; m_hold[p] = 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        v = 0; inc = 0;
        if (play_enable && pv[p] != 0 && valid_code(pc[p])) begin
          v = 1;
          if (m_trk[p][23] == pc[p]) begin v = 3; inc = 2; m_trk[p][23] = 0; end
          else if (m_trk[p][22] == pc[p]) begin v = 2; inc = 1; m_trk[p][22] = 0; end
          else if (m_trk[p][24] == pc[p]) begin v = 2; inc = 1; m_trk[p][24] = 0; end
        end
        if (st) begin
          if (v == 0 && m_trk[p][25] != 0) v = 1;
          for (int k = 25; k > 0; k--) m_trk[p][k] = m_trk[p][k-1];
          m_trk[p][0] = (chart_valid && valid_code(int'(chart_code))) ? int'(chart_code) : 0;
        end
        m_score[p] = (m_score[p] + inc > SMAX) ? SMAX : m_score[p] + inc;
        if (v != 0) begin m_ind[p] = v; m_hold[p] = HOLD - 1; end
        else if (m_hold[p] > 0) m_hold[p]--;
        else m_ind[p] = 0;
      end
      if (play_enable) m_cnt = st ? 0 : m_cnt + 1;
    end
    e.a1 = pack_trk(0); e.a2 = pack_trk(1);
    e.i1 = 2'(m_ind[0]); e.i2 = 2'(m_ind[1]);
    e.s1 = 16'(m_score[0]); e.s2 = 16'(m_score[1]);
    q.push_back(e);
    @(posedge clock);
    #1;
    g = q.pop_front();
    nvec++;
    if (p1_arrow_array !== g.a1 || p2_arrow_array !== g.a2) begin
      $display("FAIL arrays t=%0t got p1=%h p2=%h want p1=%h p2=%h", $time, p1_arrow_array, p2_arrow_array, g.a1, g.a2);
      nerr++;
    end
    nvec++;
    if (p1_indicator !== g.i1 || p2_indicator !== g.i2) begin
      $display("FAIL indicators t=%0t got %b/%b want %b/%b", $time, p1_indicator, p2_indicator, g.i1, g.i2);
      nerr++;
    end
    nvec++;
    if (p1_score !== g.s1 || p2_score !== g.s2) begin
      $display("FAIL scores t=%0t got %0d/%0d want %0d/%0d", $time, p1_score, p2_score, g.s1, g.s2);
      nerr++;
    end
  endtask

  task automatic do_steps(input int n);
    int done = 0;
    for (int i = 0; i < n * SC + SC && done < n; i++) begin
      if (play_enable && m_cnt == SC - 1) done++;
      tick();
    end
    nvec++;
    if (done != n) begin
      $display("FAIL step_budget got %0d steps want %0d", done, n);
      nerr++;
    end
  endtask

  task automatic press(input int p, input logic [2:0] c);
    if (p == 0) begin p1_press_valid = 1'b1; p1_press_code = c; end
    else begin p2_press_valid = 1'b1; p2_press_code = c; end
    tick();
    p1_press_valid = 1'b0; p2_press_valid = 1'b0;
  endtask

  task automatic insert(input logic [2:0] c);
    chart_valid = 1'b1; chart_code = c;
    do_steps(1);
    chart_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; play_enable = 1'b1; chart_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (p1_arrow_array !== '0 || p2_arrow_array !== '0 || p1_score !== 16'd0 ||
        p1_indicator !== 2'b00 || step_pulse !== 1'b0) begin
      $display("FAIL reset_state got arr=%h score=%0d ind=%b step=%b want all zero",
               p1_arrow_array, p1_score, p1_indicator, step_pulse);
      nerr++;
    end
  endtask

  task automatic test_chart_flow();
    do_reset();
    chart_valid = 1'b1;
    chart_code = 3'b001; do_steps(1);
    chart_code = 3'b010; do_steps(1);
    chart_code = 3'b011; do_steps(1);
    nvec++;
    if (p1_arrow_array[8:0] !== 9'b001_010_011 || p2_arrow_array[8:0] !== 9'b001_010_011) begin
      $display("FAIL chart_flow got p1=%b p2=%b want 001010011", p1_arrow_array[8:0], p2_arrow_array[8:0]);
      nerr++;
    end
    chart_code = 3'b111; do_steps(1);
    chart_valid = 1'b0;
    nvec++;
    if (p1_arrow_array[11:0] !== 12'b001_010_011_000) begin
      $display("FAIL chart_invalid got %b want 001010011000", p1_arrow_array[11:0]);
      nerr++;
    end
  endtask

  task automatic test_miss();
    do_reset();
    insert(3'b100);
    do_steps(25);
    nvec++;
    if (p1_arrow_array[77:75] !== 3'b100) begin
      $display("FAIL miss_slot25 got %b want 100", p1_arrow_array[77:75]);
      nerr++;
    end
    do_steps(1);
    nvec++;
    if (p1_arrow_array !== '0 || p1_indicator !== 2'b01 || p1_score !== 16'd0 || p2_indicator !== 2'b01) begin
      $display("FAIL miss_exit got arr=%h ind=%b/%b score=%0d want 0 01/01 0",
               p1_arrow_array, p1_indicator, p2_indicator, p1_score);
      nerr++;
    end
  endtask

  task automatic test_judging();
    do_reset();
    insert(3'b100); do_steps(23);
    press(0, 3'b100);
    nvec++;
    if (p1_indicator !== 2'b11 || p1_score !== 16'd2 || p1_arrow_array[71:69] !== 3'b000) begin
      $display("FAIL judge23 got ind=%b score=%0d slot=%b want 11 2 000", p1_indicator, p1_score, p1_arrow_array[71:69]);
      nerr++;
    end
    insert(3'b100); do_steps(24);
    press(0, 3'b100);
    nvec++;
    if (p1_indicator !== 2'b10 || p1_score !== 16'd3 || p1_arrow_array[74:72] !== 3'b000) begin
      $display("FAIL judge24 got ind=%b score=%0d slot=%b want 10 3 000", p1_indicator, p1_score, p1_arrow_array[74:72]);
      nerr++;
    end
    insert(3'b100); do_steps(20);
    press(0, 3'b100);
    nvec++;
    if (p1_indicator !== 2'b01 || p1_score !== 16'd3 || p1_arrow_array[62:60] !== 3'b100) begin
      $display("FAIL judge20 got ind=%b score=%0d slot=%b want 01 3 100", p1_indicator, p1_score, p1_arrow_array[62:60]);
      nerr++;
    end
  endtask

  task automatic test_step_press();
    int guard = 0;
    do_reset();
    insert(3'b100); do_steps(22);
    while (m_cnt != SC - 1 && guard < 2 * SC) begin tick(); guard++; end
    press(0, 3'b100);
    nvec++;
    if (p1_indicator !== 2'b10 || p1_score !== 16'd1 || p1_arrow_array[71:69] !== 3'b000 ||
        p2_arrow_array[71:69] !== 3'b100) begin
      $display("FAIL step_press got ind=%b score=%0d p1slot23=%b p2slot23=%b want 10 1 000 100",
               p1_indicator, p1_score, p1_arrow_array[71:69], p2_arrow_array[71:69]);
      nerr++;
    end
  endtask

  task automatic test_freeze();
    logic [77:0] snap;
    do_reset();
    insert(3'b011); do_steps(1);
    tick();
    press(0, 3'b011);
    play_enable = 1'b0;
    snap = pack_trk(0);
    for (int i = 0; i < 100; i++) begin
      if (i == 10) press(0, 3'b011);
      else if (i == 30) press(1, 3'b110);
      else tick();
    end
    nvec++;
    if (p1_arrow_array !== snap || p1_indicator !== 2'b00 || dut.step_cnt !== 2'(m_cnt)) begin
      $display("FAIL freeze got arr=%h ind=%b want arr=%h ind=00", p1_arrow_array, p1_indicator, snap);
      nerr++;
    end
    play_enable = 1'b1;
    do_steps(2);
  endtask

  task automatic test_reset_mid();
    do_reset();
    insert(3'b100); do_steps(18);
    insert(3'b010); do_steps(5);
    nvec++;
    if (p1_arrow_array[74:72] !== 3'b100 || p1_arrow_array[17:15] !== 3'b010) begin
      $display("FAIL premid got slot24=%b slot5=%b want 100 010", p1_arrow_array[74:72], p1_arrow_array[17:15]);
      nerr++;
    end
    reset = 1'b1; tick(); reset = 1'b0;
    nvec++;
    if (p1_arrow_array !== '0 || p2_arrow_array !== '0 || p1_indicator !== 2'b00 || p2_indicator !== 2'b00) begin
      $display("FAIL reset_mid got arr=%h ind=%b/%b want 0 00/00", p1_arrow_array, p1_indicator, p2_indicator);
      nerr++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      insert(3'b101); do_steps(23);
      press(0, 3'b101);
    end
    nvec++;
    if (p1_score !== 16'(SMAX) || p2_score !== 16'd0) begin
      $display("FAIL saturation got %0d/%0d want %0d/0", p1_score, p2_score, SMAX);
      nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_chart_flow();
    test_miss();
    test_judging();
    test_step_press();
    test_freeze();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
